// File: rtl/shared_pkg.sv
// Types and constants shared by the sync FIFO and its read-side stream adapter.
package shared_pkg;

  localparam int unsigned FIFO_WIDTH   = 16;
  localparam int unsigned RD_BUF_DEPTH = 2;

  typedef enum logic [1:0] {
    BUF_EMPTY = 2'd0,
    BUF_ONE   = 2'd1,
    BUF_FULL  = 2'd2
  } rd_buf_state_e;

  function automatic logic [1:0] buf_occ(rd_buf_state_e st);
    unique case (st)
      BUF_ONE:  return 2'd1;
      BUF_FULL: return 2'd2;
      default:  return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/fifo_rd_if.sv
// FIFO read-side and stream-side signal bundle, with one modport per side.
interface fifo_rd_if #(
  parameter int unsigned W = 16
) (
  input logic clk
);
  logic         fifo_empty;
  logic         fifo_underflow;
  logic [W-1:0] fifo_data_out;
  logic         fifo_rd_en;
  logic         m_valid;
  logic         m_ready;
  logic [W-1:0] m_data;

  modport Fifo (
    input  clk, fifo_rd_en,
    output fifo_empty, fifo_underflow, fifo_data_out
  );

  modport Stream (
    input  clk, m_valid, m_data,
    output m_ready
  );
endinterface

// File: rtl/rd_skid_buf.sv
// Two-entry in-order buffer with registered head; knows nothing about the FIFO.
module rd_skid_buf
  import shared_pkg::*;
#(
  parameter int unsigned DATA_W = FIFO_WIDTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [1:0]        occ,
  output logic [DATA_W-1:0] head
);

  rd_buf_state_e     state_q, state_d;
  logic [DATA_W-1:0] head_q, head_d;
  logic [DATA_W-1:0] tail_q, tail_d;

  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    tail_d  = tail_q;
    case (state_q)
      BUF_EMPTY: begin
        if (push) begin
          head_d  = push_data;
          state_d = BUF_ONE;
        end
      end
      BUF_ONE: begin
        if (push && pop) begin
          head_d = push_data;
        end else if (push) begin
          tail_d  = push_data;
          state_d = BUF_FULL;
        end else if (pop) begin
          state_d = BUF_EMPTY;
        end
      end
      BUF_FULL: begin
        if (pop) begin
          head_d = tail_q;
          if (push) tail_d = push_data;
          else      state_d = BUF_ONE;
        end
      end
      default: state_d = BUF_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= BUF_EMPTY;
      head_q  <= '0;
      tail_q  <= '0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
    end
  end

  assign occ  = buf_occ(state_q);
  assign head = head_q;

  // The issue logic upstream must never let the buffer overflow or pop while empty.
  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(push && !pop && state_q == BUF_FULL));
  a_no_empty_pop: assert property (@(posedge clk) disable iff (rst)
    !(pop && state_q == BUF_EMPTY));

endmodule

// File: rtl/fifo_rd_stream.sv
// Sync-FIFO read adapter: issues rd_en, captures the 1-cycle-late data, presents valid/ready.
// Optional statistics counters are built only when FIFO_RD_STREAM_STATS_EN is defined.
module fifo_rd_stream
  import shared_pkg::*;
#(
  parameter int unsigned DATA_W = shared_pkg::FIFO_WIDTH,
  parameter int unsigned STAT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fifo_empty,
  input  logic              fifo_underflow,
  input  logic [DATA_W-1:0] fifo_data_out,
  output logic              fifo_rd_en,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              err_underflow,
  output logic [STAT_W-1:0] stat_words,
  output logic [STAT_W-1:0] stat_stall
);

  logic [1:0] occ;
  logic [1:0] committed;
  logic       pop;
  logic       inflight_q, inflight_d;
  logic       err_q, err_d;

  rd_skid_buf #(
    .DATA_W (DATA_W)
  ) u_buf (
    .clk       (clk),
    .rst       (rst),
    .push      (inflight_q),
    .push_data (fifo_data_out),
    .pop       (pop),
    .occ       (occ),
    .head      (m_data)
  );

  assign m_valid = (occ != 2'd0);
  assign pop     = m_valid & m_ready;

  // Words held plus the one in flight; a read is safe if it stays within the buffer depth.
  assign committed  = occ + {1'b0, inflight_q};
  assign fifo_rd_en = !rst && !fifo_empty && ((committed < 2'(RD_BUF_DEPTH)) || pop);

  always_comb begin
    inflight_d = fifo_rd_en;
    err_d      = err_q | fifo_underflow;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      inflight_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      inflight_q <= inflight_d;
      err_q      <= err_d;
    end
  end

  assign err_underflow = err_q;

`ifdef FIFO_RD_STREAM_STATS_EN
  logic [STAT_W-1:0] words_q, words_d;
  logic [STAT_W-1:0] stall_q, stall_d;

  always_comb begin
    words_d = words_q;
    stall_d = stall_q;
    if (pop && (words_q != '1))                  words_d = words_q + 1'b1;
    if (m_valid && !m_ready && (stall_q != '1))  stall_d = stall_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      words_q <= '0;
      stall_q <= '0;
    end else begin
      words_q <= words_d;
      stall_q <= stall_d;
    end
  end

  assign stat_words = words_q;
  assign stat_stall = stall_q;
`else
  assign stat_words = '0;
  assign stat_stall = '0;
`endif

endmodule
